pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage stalling CPU. It keeps a shadow scoreboard of in-flight destination registers for EX, MEM and WB, detects RAW hazards for the instruction in ID, and drives stall, bubble and flush controls into PC, IF/ID and ID/EX. It also sequences halt/drain/resume and provides cycle, stall, flush and retire counters. It sits beside the ID stage and is the only source of pipeline-register control.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/hazard_match.sv | 31 +++
 rtl/pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline sequencing controller.
//   state_t     - controller FSM encoding (also exported on the debug port)
//   sb_entry_t  - one shadow-scoreboard entry {valid, wreg, dest}
//   NOP_DEST    - destination used by empty entries ($0 is never a hazard)
//   entry_match - RAW match of one source register against one entry
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic [4:0] dest;
    } sb_entry_t;

    localparam logic [4:0] NOP_DEST = 5'd0;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wreg: 1'b0, dest: NOP_DEST};

    // $0 is hardwired to zero, so a read of it can never depend on a writer.
    function automatic logic entry_match(sb_entry_t e, logic [4:0] r);
        return e.wreg && (e.dest == r) && (r != NOP_DEST);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational RAW compare of one source register against
// the EX/MEM/WB scoreboard entries.
//   WB_HAZARD - 1: the WB entry also matches (register file writes on rising edge)
//   src       - source register number read by the ID instruction
//   sb0..sb2  - packed sb_entry_t for EX, MEM, WB
//   match     - src is produced by an in-flight instruction not yet visible
module hazard_match
    import pipe_ctrl_pkg::*;
#(
    parameter bit WB_HAZARD = 1'b0
) (
    input  logic [4:0] src,
    input  logic [6:0] sb0,
    input  logic [6:0] sb1,
    input  logic [6:0] sb2,
    output logic       match
);

    sb_entry_t e0, e1, e2;

    assign e0 = sb_entry_t'(sb0);
    assign e1 = sb_entry_t'(sb1);
    assign e2 = sb_entry_t'(sb2);

    // With a falling-edge register file the WB value is already readable in ID,
    // so the WB entry only counts when the file writes on the rising edge.
    assign match = entry_match(e0, src)
                 | entry_match(e1, src)
                 | (WB_HAZARD & entry_match(e2, src));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 5-stage stalling CPU.
// Tracks in-flight destinations (EX/MEM/WB), detects RAW hazards for the ID
// instruction, and is the only source of PC / IF/ID / ID/EX control.
//   clk, rst          - clock, synchronous active-high reset
//   id_*              - ID instruction: valid, sources, source use, dest write
//   ex_branch_taken   - EX branch resolved taken (flush wrong-path fetches)
//   halt_req, resume  - drain-and-halt request, leave HALTED
//   stall/bubble/flush- hold PC+IF/ID / NOP into ID/EX / clear IF/ID
//   halted, state     - halt status and FSM state (debug)
//   *_cnt             - wrapping performance counters, CNT_W bits
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit WB_HAZARD = 1'b0,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [4:0]       id_destR,
    input  logic             ex_branch_taken,
    input  logic             halt_req,
    input  logic             resume,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    state_t    state_q, state_d;
    sb_entry_t sb0_q, sb1_q, sb2_q;
    sb_entry_t sb0_d;
    logic      rs_match, rt_match, hazard;
    logic      run_like;

    hazard_match #(.WB_HAZARD(WB_HAZARD)) u_match_rs (
        .src   (id_rs),
        .sb0   (sb0_q),
        .sb1   (sb1_q),
        .sb2   (sb2_q),
        .match (rs_match)
    );

    hazard_match #(.WB_HAZARD(WB_HAZARD)) u_match_rt (
        .src   (id_rt),
        .sb0   (sb0_q),
        .sb1   (sb1_q),
        .sb2   (sb2_q),
        .match (rt_match)
    );

    assign hazard   = id_valid & ((id_use_rs & rs_match) | (id_use_rt & rt_match));
    assign run_like = (state_q == RUN) || (state_q == STALL);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        halted = 1'b0;
        unique case (state_q)
            RUN, STALL: begin
                stall  = hazard;
                bubble = hazard;
            end
            DRAIN: begin
                stall  = 1'b1;
                bubble = 1'b1;
            end
            HALTED: begin
                stall  = 1'b1;
                bubble = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
        // The ID instruction is wrong-path after a taken branch, so the branch
        // wins over any hazard; PC is only released while running.
        if (ex_branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
            if (run_like) stall = 1'b0;
        end
        if (rst) begin
            stall  = 1'b0;
            bubble = 1'b1;
            flush  = 1'b1;
            halted = 1'b0;
        end
    end

    // The EX entry only receives the ID instruction when it actually issues.
    always_comb begin
        sb0_d = SB_EMPTY;
        if (!bubble) begin
            sb0_d.valid = id_valid;
            sb0_d.wreg  = id_wreg & (id_destR != NOP_DEST);
            sb0_d.dest  = id_destR;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (halt_req)    state_d = DRAIN;
                else if (hazard) state_d = STALL;
            end
            STALL: begin
                if (halt_req)     state_d = DRAIN;
                else if (!hazard) state_d = RUN;
            end
            DRAIN: begin
                // Empty on the next-state scoreboard: sb1<=sb0, sb2<=sb1.
                if (!sb0_d.valid && !sb0_q.valid && !sb1_q.valid) state_d = HALTED;
            end
            HALTED: begin
                if (resume) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: the scoreboard is reset along with the FSM because its valid bits
    // drive hazard detection and drain completion; stale entries would stall
    // or hang the pipeline after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            sb0_q      <= SB_EMPTY;
            sb1_q      <= SB_EMPTY;
            sb2_q      <= SB_EMPTY;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            state_q    <= state_d;
            sb0_q      <= sb0_d;
            sb1_q      <= sb0_q;
            sb2_q      <= sb1_q;
            cycle_cnt  <= cycle_cnt + CNT_W'(1);
            // In RUN/STALL, stall is already masked by a taken branch.
            stall_cnt  <= stall_cnt + CNT_W'(run_like & stall);
            flush_cnt  <= flush_cnt + CNT_W'(flush);
            retire_cnt <= retire_cnt + CNT_W'(sb2_q.valid);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl. Two instances
// share all stimulus: dut (WB_HAZARD=0) and dut_wb (WB_HAZARD=1). dut_wb is
// only compared after the common reset in the last segment.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rs, id_use_rt;
    logic        id_wreg;
    logic [4:0]  id_destR;
    logic        ex_branch_taken;
    logic        halt_req;
    logic        resume;

    logic        stall, bubble, flush, halted;
    logic [1:0]  state;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt, retire_cnt;

    logic        w_stall, w_bubble, w_flush, w_halted;
    logic [1:0]  w_state;
    logic [31:0] w_cycle_cnt, w_stall_cnt, w_flush_cnt, w_retire_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.WB_HAZARD(1'b0), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_wreg         (id_wreg),
        .id_destR        (id_destR),
        .ex_branch_taken (ex_branch_taken),
        .halt_req        (halt_req),
        .resume          (resume),
        .stall           (stall),
        .bubble          (bubble),
        .flush           (flush),
        .halted          (halted),
        .state           (state),
        .cycle_cnt       (cycle_cnt),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .retire_cnt      (retire_cnt)
    );

    pipe_ctrl #(.WB_HAZARD(1'b1), .CNT_W(32)) dut_wb (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_wreg         (id_wreg),
        .id_destR        (id_destR),
        .ex_branch_taken (ex_branch_taken),
        .halt_req        (halt_req),
        .resume          (resume),
        .stall           (w_stall),
        .bubble          (w_bubble),
        .flush           (w_flush),
        .halted          (w_halted),
        .state           (w_state),
        .cycle_cnt       (w_cycle_cnt),
        .stall_cnt       (w_stall_cnt),
        .flush_cnt       (w_flush_cnt),
        .retire_cnt      (w_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic w, input logic [4:0] d);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wreg   = w;
        id_destR  = d;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        ex_branch_taken = 1'b0;
        halt_req        = 1'b0;
        resume          = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before negedge).
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #3;
        check("rst_stall",  {31'd0, stall},  32'd0);
        check("rst_bubble", {31'd0, bubble}, 32'd1);
        check("rst_flush",  {31'd0, flush},  32'd1);
        check("rst_halted", {31'd0, halted}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // ---- EX dependency: add $3,$1,$2 ; sub $5,$3,$4 ----
        // c0
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3);
        settle();
        check("reset_state",  {30'd0, state}, 32'd0);
        check("reset_cycle",  cycle_cnt,  32'd0);
        check("reset_retire", retire_cnt, 32'd0);
        check("add_no_stall", {31'd0, stall}, 32'd0);
        tick();
        // c1: $3 in EX
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5);
        settle();
        check("ex_dep_stall",  {31'd0, stall},  32'd1);
        check("ex_dep_bubble", {31'd0, bubble}, 32'd1);
        tick();
        // c2: $3 in MEM
        settle();
        check("mem_dep_state", {30'd0, state}, 32'd1);
        check("mem_dep_stall", {31'd0, stall}, 32'd1);
        tick();
        // c3: $3 in WB, falling-edge register file -> issues
        settle();
        check("wb_nohaz_stall",  {31'd0, stall},  32'd0);
        check("wb_nohaz_bubble", {31'd0, bubble}, 32'd0);
        tick();
        // c4
        idle();
        settle();
        check("ex_dep_stall_cnt", stall_cnt,  32'd2);
        check("c4_cycle_cnt",     cycle_cnt,  32'd4);
        check("c4_retire_cnt",    retire_cnt, 32'd1);
        check("c4_state_run",     {30'd0, state}, 32'd0);
        tick();
        tick();
        tick();

        // ---- $0 destination and unused-operand cases ----
        // c7: writes $0
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
        settle();
        check("w0_issue_stall", {31'd0, stall}, 32'd0);
        tick();
        // c8: reads $0, writes $7
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7);
        settle();
        check("r0_no_stall", {31'd0, stall}, 32'd0);
        tick();
        // c9: rt=7 pending but not used
        set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0);
        settle();
        check("unused_rt_no_stall", {31'd0, stall}, 32'd0);
        tick();
        // c10: rs=7 used, $7 in MEM
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        settle();
        check("used_rs_stall", {31'd0, stall}, 32'd1);
        tick();
        // c11
        idle();
        settle();
        check("c11_state_stall", {30'd0, state}, 32'd1);
        check("c11_no_stall",    {31'd0, stall}, 32'd0);
        tick();

        // ---- Branch over hazard ----
        // c12: writes $9
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9);
        tick();
        // c13: reads $9 (EX) while branch taken
        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10);
        ex_branch_taken = 1'b1;
        settle();
        check("br_flush",  {31'd0, flush},  32'd1);
        check("br_bubble", {31'd0, bubble}, 32'd1);
        check("br_stall",  {31'd0, stall},  32'd0);
        tick();
        // c14: flushed instruction's $10 must not be in the scoreboard
        ex_branch_taken = 1'b0;
        set_id(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        settle();
        check("br_stall_cnt",     stall_cnt, 32'd3);
        check("br_flush_cnt",     flush_cnt, 32'd1);
        check("br_sb0_empty",     {31'd0, stall}, 32'd0);
        check("br_flush_one_cyc", {31'd0, flush}, 32'd0);
        tick();

        // ---- Drain and resume ----
        // c15, c16: A, B
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12);
        tick();
        // c17: C plus halt_req pulse
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13);
        halt_req = 1'b1;
        settle();
        check("halt_req_state_run", {30'd0, state}, 32'd0);
        tick();
        // c18
        idle();
        settle();
        check("drain1_state",  {30'd0, state},  32'd2);
        check("drain1_stall",  {31'd0, stall},  32'd1);
        check("drain1_bubble", {31'd0, bubble}, 32'd1);
        check("drain1_halted", {31'd0, halted}, 32'd0);
        check("drain1_retire", retire_cnt, 32'd7);
        tick();
        // c19: resume ignored in DRAIN
        resume = 1'b1;
        settle();
        check("drain2_state", {30'd0, state}, 32'd2);
        tick();
        // c20
        resume = 1'b0;
        settle();
        check("drain3_state", {30'd0, state}, 32'd2);
        tick();
        // c21
        settle();
        check("halted_state",  {30'd0, state},  32'd3);
        check("halted_flag",   {31'd0, halted}, 32'd1);
        check("halted_stall",  {31'd0, stall},  32'd1);
        check("halted_retire", retire_cnt, 32'd10);
        resume = 1'b1;
        tick();
        // c22: halt_req and branch together
        resume          = 1'b0;
        halt_req        = 1'b1;
        ex_branch_taken = 1'b1;
        settle();
        check("resume_state",  {30'd0, state},  32'd0);
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("c22_cycle_cnt", cycle_cnt, 32'd22);
        check("hb_flush",      {31'd0, flush},  32'd1);
        check("hb_stall",      {31'd0, stall},  32'd0);
        tick();
        // c23: empty pipeline -> one DRAIN cycle
        idle();
        settle();
        check("hb_state_drain", {30'd0, state}, 32'd2);
        check("hb_flush_cnt",   flush_cnt, 32'd2);
        tick();
        // c24: branch while HALTED
        ex_branch_taken = 1'b1;
        settle();
        check("empty_halted_state", {30'd0, state}, 32'd3);
        check("halted_br_flush",    {31'd0, flush}, 32'd1);
        check("halted_br_stall",    {31'd0, stall}, 32'd1);
        tick();
        ex_branch_taken = 1'b0;
        resume          = 1'b1;
        tick();
        resume = 1'b0;

        // ---- Mid-stall reset, then WB_HAZARD comparison ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // r0: writes $20
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd20);
        tick();
        // r1: reads $20 in EX
        set_id(1'b1, 5'd20, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
        settle();
        check("r1_stall",    {31'd0, stall},   32'd1);
        check("r1_wb_stall", {31'd0, w_stall}, 32'd1);
        tick();
        // r2: STALL, assert reset
        settle();
        check("r2_state_stall", {30'd0, state}, 32'd1);
        rst = 1'b1;
        settle();
        check("midrst_stall",  {31'd0, stall},  32'd0);
        check("midrst_bubble", {31'd0, bubble}, 32'd1);
        check("midrst_flush",  {31'd0, flush},  32'd1);
        tick();
        // r3: $20 would be in WB if the scoreboard survived
        rst = 1'b0;
        settle();
        check("midrst_state",  {30'd0, state}, 32'd0);
        check("midrst_cycle",  cycle_cnt,  32'd0);
        check("midrst_stallc", stall_cnt,  32'd0);
        check("midrst_flushc", flush_cnt,  32'd0);
        check("midrst_retire", retire_cnt, 32'd0);
        check("midrst_sb_clr", {31'd0, w_stall}, 32'd0);
        tick();
        // r4: writes $21; r5, r6 idle
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd21);
        tick();
        idle();
        tick();
        tick();
        // r7: reads rt=$21 while it is in WB
        set_id(1'b1, 5'd0, 5'd21, 1'b0, 1'b1, 1'b0, 5'd0);
        settle();
        check("wb0_stall", {31'd0, stall},   32'd0);
        check("wb1_stall", {31'd0, w_stall}, 32'd1);
        tick();
        // r8
        idle();
        settle();
        check("wb1_stall_cnt", w_stall_cnt, 32'd1);
        check("wb0_stall_cnt", stall_cnt,   32'd0);
        check("wb1_state",     {30'd0, w_state}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
